// File: rtl/key_button_mapper.sv
// Maps ps2_key events and a joystick word onto a button vector using a runtime-writable keymap table.
// Optional press stretcher enabled by defining KEYMAP_STRETCH_EN.
module key_button_mapper #(
  parameter int unsigned NUM_BUTTONS  = 12,
  parameter int unsigned JOY_WIDTH    = 16,
  parameter logic [7:0]  KEYMAP_INDEX = 8'd2,
  parameter int unsigned HOLD_W       = 16,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = 16'd42954
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [JOY_WIDTH-1:0]   joystick,
  input  logic [15:0]            dn_addr,
  input  logic [7:0]             dn_data,
  input  logic                   dn_wr,
  input  logic [7:0]             dn_index,
  output logic [NUM_BUTTONS-1:0] inputs,
  output logic                   key_any
);

  localparam int unsigned TABLE_BYTES = 2 * NUM_BUTTONS;

  typedef logic [NUM_BUTTONS-1:0][7:0] table_t;

  function automatic logic [7:0] dflt_code(input int unsigned i);
    case (i)
      0:  return 8'h1C;
      1:  return 8'h1A;
      2:  return 8'h2A;
      3:  return 8'h2B;
      4:  return 8'h1B;
      5:  return 8'h22;
      6:  return 8'h14;
      7:  return 8'h66;
      8:  return 8'h23;
      9:  return 8'h21;
      10: return 8'h16;
      11: return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  // Attribute byte: key_en and joy_en set, joystick bit index in [4:0].
  function automatic logic [7:0] dflt_attr(input int unsigned i);
    case (i)
      0:  return 8'h64;
      1:  return 8'h61;
      2:  return 8'h60;
      3:  return 8'h67;
      4:  return 8'h65;
      5:  return 8'h63;
      6:  return 8'h68;
      7:  return 8'h69;
      8:  return 8'h66;
      9:  return 8'h62;
      10: return 8'h68;
      11: return 8'h6A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic table_t init_code();
    table_t t;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) t[i] = dflt_code(i);
    return t;
  endfunction

  function automatic table_t init_attr();
    table_t t;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) t[i] = dflt_attr(i);
    return t;
  endfunction

  // Table is loaded with the default map at configuration and is outside the reset domain.
  table_t code_q = init_code();
  table_t attr_q = init_attr();
  table_t code_d, attr_d;

  logic                   tog_q;
  logic [NUM_BUTTONS-1:0] key_state_q, key_state_d;
  logic [NUM_BUTTONS-1:0] inputs_q, inputs_d;
  logic                   key_any_q, key_any_d;
  logic [NUM_BUTTONS-1:0] joy_bit_c;
  logic [NUM_BUTTONS-1:0] stretch_c;
  logic                   wr_hit_c;
  logic                   key_evt_c;
  logic [31:0]            joy_ext_c;

  always_comb begin
    code_d      = code_q;
    attr_d      = attr_q;
    key_state_d = key_state_q;
    joy_bit_c   = '0;
    joy_ext_c   = 32'(joystick);
    wr_hit_c    = dn_wr && (dn_index == KEYMAP_INDEX) && (dn_addr < 16'(TABLE_BYTES));
    key_evt_c   = (ps2_key[10] != tog_q);

    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (wr_hit_c && (dn_addr[15:1] == 15'(i))) begin
        if (dn_addr[0]) attr_d[i] = dn_data;
        else            code_d[i] = dn_data;
      end
      joy_bit_c[i] = attr_q[i][6] & joy_ext_c[attr_q[i][4:0]];
    end

    // A table write wins over a coincident key event and drops all held keys.
    if (wr_hit_c) begin
      key_state_d = '0;
    end else if (key_evt_c) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (attr_q[i][5] && (code_q[i] == ps2_key[7:0]) && (attr_q[i][7] == ps2_key[8]))
          key_state_d[i] = ps2_key[9];
      end
    end

    inputs_d  = key_state_q | joy_bit_c | stretch_c;
    key_any_d = |key_state_q;
  end

  always_ff @(posedge clk) begin
    code_q <= code_d;
    attr_q <= attr_d;
  end

  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (reset) begin
      key_state_q <= '0;
      inputs_q    <= '0;
      key_any_q   <= 1'b0;
    end else begin
      key_state_q <= key_state_d;
      inputs_q    <= inputs_d;
      key_any_q   <= key_any_d;
    end
  end

`ifdef KEYMAP_STRETCH_EN
  logic [NUM_BUTTONS-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_BUTTONS-1:0]             key_prev_q, key_prev_d;

  // Hold counter reloads on each new press and counts down to zero.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    key_prev_d = key_state_q;
    stretch_c  = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      stretch_c[i] = (hold_cnt_q[i] != '0);
      if (key_state_q[i] && !key_prev_q[i])
        hold_cnt_d[i] = HOLD_CYCLES - HOLD_W'(1);
      else if (hold_cnt_q[i] != '0)
        hold_cnt_d[i] = hold_cnt_q[i] - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
      key_prev_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      key_prev_q <= key_prev_d;
    end
  end
`else
  logic unused_hold_c;
  assign unused_hold_c = ^{HOLD_CYCLES, HOLD_W[0]};
  assign stretch_c     = '0;
`endif

  assign inputs  = inputs_q;
  assign key_any = key_any_q;

endmodule

// File: tb/tb_key_button_mapper.sv
// Self-checking bench for key_button_mapper: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_key_button_mapper;

  localparam int NB   = 12;
  localparam int JW   = 16;
  localparam int HOLD = 100;
`ifdef KEYMAP_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [JW-1:0] joystick;
  logic [15:0]   dn_addr;
  logic [7:0]    dn_data;
  logic          dn_wr;
  logic [7:0]    dn_index;
  logic [NB-1:0] inputs;
  logic          key_any;

  key_button_mapper #(
    .NUM_BUTTONS(NB), .JOY_WIDTH(JW), .KEYMAP_INDEX(8'd2),
    .HOLD_W(16), .HOLD_CYCLES(16'(HOLD))
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_index(dn_index),
    .inputs(inputs), .key_any(key_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: table bytes, per-key pressed state, and the cycle each key last went down.
  logic [7:0]    m_code [NB];
  logic [7:0]    m_attr [NB];
  logic          m_tog = 1'b0;
  logic [NB-1:0] m_ks = '0;
  logic [NB-1:0] m_inputs = '0;
  logic          m_key_any = 1'b0;
  int            m_rise [NB];
  bit            m_rise_ok [NB];
  int            cyc = 0;

  initial begin
    logic [7:0] codes [NB];
    int         joys  [NB];
    codes = '{8'h1C, 8'h1A, 8'h2A, 8'h2B, 8'h1B, 8'h22, 8'h14, 8'h66, 8'h23, 8'h21, 8'h16, 8'h11};
    joys  = '{4, 1, 0, 7, 5, 3, 8, 9, 6, 2, 8, 10};
    for (int i = 0; i < NB; i++) begin
      m_code[i]    = codes[i];
      m_attr[i]    = 8'h60 | 8'(joys[i]);
      m_rise[i]    = 0;
      m_rise_ok[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    logic [NB-1:0] nin;
    logic [NB-1:0] nks;
    bit            wr, evt, jb, st;
    int            idx;
    cyc++;
    for (int i = 0; i < NB; i++) begin
      idx = int'(m_attr[i][4:0]);
      jb  = m_attr[i][6] && (idx < JW) && joystick[idx];
      st  = STRETCH && m_rise_ok[i] && (cyc - m_rise[i] <= HOLD);
      nin[i] = m_ks[i] | jb | st;
    end
    wr  = dn_wr && dn_index == 8'd2 && dn_addr < 16'(2*NB);
    evt = ps2_key[10] != m_tog;
    nks = m_ks;
    if (wr) nks = '0;
    else if (evt)
      for (int i = 0; i < NB; i++)
        if (m_attr[i][5] && m_code[i] == ps2_key[7:0] && m_attr[i][7] == ps2_key[8])
          nks[i] = ps2_key[9];
    if (wr) begin
      if (dn_addr[0]) m_attr[dn_addr[15:1]] = dn_data;
      else            m_code[dn_addr[15:1]] = dn_data;
    end
    m_tog = ps2_key[10];
    if (reset) begin
      m_inputs  = '0;
      m_key_any = 1'b0;
      m_ks      = '0;
      for (int i = 0; i < NB; i++) m_rise_ok[i] = 1'b0;
    end else begin
      m_inputs  = nin;
      m_key_any = |m_ks;
      for (int i = 0; i < NB; i++)
        if (nks[i] && !m_ks[i]) begin
          m_rise[i]    = cyc;
          m_rise_ok[i] = 1'b1;
        end
      m_ks = nks;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_key(input logic pr, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  task automatic tbl_write(input logic [15:0] a, input logic [7:0] d);
    dn_wr = 1'b1; dn_index = 8'd2; dn_addr = a; dn_data = d;
    tick(1);
    dn_wr = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    logic [7:0] pool [14];
    pool = '{8'h1C, 8'h1A, 8'h2A, 8'h2B, 8'h1B, 8'h22, 8'h14, 8'h66, 8'h23, 8'h21, 8'h16, 8'h11, 8'h29, 8'h00};
    reset = 1'b1; ps2_key = '0; joystick = '0;
    dn_addr = '0; dn_data = '0; dn_wr = 1'b0; dn_index = '0;
    tick(3);
    check_eq("reset_inputs", 32'(inputs), 32'h0);
    check_eq("reset_key_any", 32'(key_any), 32'h0);
    reset = 1'b0;
    tick(2);
    check_eq("idle_after_reset", 32'(inputs), 32'h0);

    // Single key with two-cycle latency
    send_key(1'b1, 1'b0, 8'h1C);
    tick(1);
    check_eq("press_1c_lat1", 32'(inputs), 32'h0);
    tick(1);
    check_eq("press_1c", 32'(inputs), 32'h001);
    check_eq("press_1c_any", 32'(key_any), 32'h1);
    send_key(1'b0, 1'b0, 8'h1C);
    tick(2 + (STRETCH ? HOLD : 0));
    check_eq("release_1c", 32'(inputs), 32'h0);
    check_eq("release_1c_any", 32'(key_any), 32'h0);

    // Extended code distinguishes RCtrl from LCtrl
    send_key(1'b1, 1'b1, 8'h14);
    tick(2);
    check_eq("rctrl_ignored", 32'(inputs), 32'h0);
    send_key(1'b1, 1'b0, 8'h14);
    tick(2);
    check_eq("lctrl_bit6", 32'(inputs), 32'h040);

    // Joystick merge
    joystick = 16'h0100;
    tick(1);
    check_eq("joy_bit8", 32'(inputs), 32'h440);
    joystick = 16'h0000;
    tick(1);
    check_eq("joy_off_key_held", 32'(inputs), 32'h040);
    joystick = 16'h0010;
    tick(1);
    check_eq("joy_bit4", 32'(inputs), 32'h041);
    joystick = 16'h0000;
    send_key(1'b0, 1'b0, 8'h14);
    tick(2 + (STRETCH ? HOLD : 0));
    check_eq("release_14", 32'(inputs), 32'h0);

    // Remap button 0 to scancode 29 with an out-of-range joystick index
    tbl_write(16'd0, 8'h29);
    tbl_write(16'd1, 8'h3F);
    send_key(1'b1, 1'b0, 8'h1C);
    tick(2);
    check_eq("old_key_unmapped", 32'(inputs), 32'h0);
    send_key(1'b0, 1'b0, 8'h1C);
    joystick = 16'hFFFF;
    tick(1);
    check_eq("joy_idx31_off", 32'(inputs), 32'hFFE);
    joystick = 16'h0000;
    send_key(1'b1, 1'b0, 8'h29);
    tick(2);
    check_eq("new_key_29", 32'(inputs), 32'h001);
    tbl_write(16'd24, 8'h55);
    tick(2);
    check_eq("oob_write_ignored", 32'(inputs), 32'h001);
    tbl_write(16'd2, 8'h1A);
    tick(1);
    check_eq("write_clears_keys", 32'(inputs), 32'h0);
    check_eq("write_clears_any", 32'(key_any), 32'h0);
    tbl_write(16'd0, 8'h1C);
    tbl_write(16'd1, 8'h64);
    send_key(1'b0, 1'b0, 8'h29);
    tick(2 + (STRETCH ? HOLD : 0));

    // Ps2 event coincident with a table write is dropped
    send_key(1'b1, 1'b0, 8'h1C);
    dn_wr = 1'b1; dn_index = 8'd2; dn_addr = 16'd2; dn_data = 8'h1A;
    tick(1);
    dn_wr = 1'b0;
    tick(1);
    check_eq("collision_dropped", 32'(inputs), 32'h0);
    send_key(1'b1, 1'b0, 8'h1C);
    tick(2);
    check_eq("press_after_collision", 32'(inputs), 32'h001);

    // Reset mid-hold
    reset = 1'b1;
    tick(1);
    check_eq("reset_mid_hold", 32'(inputs), 32'h0);
    reset = 1'b0;
    tick(3);
    check_eq("no_event_after_reset", 32'(inputs), 32'h0);
    check_eq("no_event_after_reset_any", 32'(key_any), 32'h0);

    // Tap of one cycle: stretched to HOLD cycles, or a single cycle without stretcher
    send_key(1'b1, 1'b0, 8'h1A);
    tick(1);
    send_key(1'b0, 1'b0, 8'h1A);
    hi_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      if (inputs[1]) hi_cnt++;
    end
    check_eq("tap_high_cycles", 32'(hi_cnt), STRETCH ? 32'(HOLD) : 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      check_eq("rand_inputs", 32'(inputs), 32'(m_inputs));
      check_eq("rand_key_any", 32'(key_any), 32'(m_key_any));
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(99) < 30)
        send_key(1'($urandom), ($urandom_range(4) == 0), pool[$urandom_range(13)]);
      if ($urandom_range(9) == 0) joystick = JW'($urandom);
      dn_wr = ($urandom_range(29) == 0);
      dn_index = ($urandom_range(9) == 0) ? 8'd3 : 8'd2;
      dn_addr = 16'($urandom_range(27));
      dn_data = ($urandom_range(1) == 0) ? pool[$urandom_range(13)] : 8'($urandom);
      tick(1);
    end
    check_eq("rand_final_inputs", 32'(inputs), 32'(m_inputs));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
